// File: rtl/dnn_dma_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dnn_dma_rd_arbiter
// Description : Round-robin arbiter sharing one 64-bit DMA read port (ctrl +
//               beat channel) among NUM_REQ requesters, one burst at a time.
// Revision    : 1.0 - initial release
// ============================================================================
module dnn_dma_rd_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [NUM_REQ*32-1:0]  req_index,
    input  logic [NUM_REQ*32-1:0]  req_length,
    input  logic [NUM_REQ*3-1:0]   req_size,
    output logic [NUM_REQ-1:0]     rd_valid,
    input  logic [NUM_REQ-1:0]     rd_ready,
    output logic [63:0]            rd_data,
    output logic                   dma_read_ctrl_valid,
    input  logic                   dma_read_ctrl_ready,
    output logic [31:0]            dma_read_ctrl_data_index,
    output logic [31:0]            dma_read_ctrl_data_length,
    output logic [2:0]             dma_read_ctrl_data_size,
    input  logic                   dma_read_chnl_valid,
    output logic                   dma_read_chnl_ready,
    input  logic [63:0]            dma_read_chnl_data,
    output logic                   busy,
    output logic [ID_W-1:0]        grant_id
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CTRL   = 2'd1,
        S_STREAM = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic [ID_W-1:0] r_last_ptr;
    logic [ID_W-1:0] r_grant_id;
    logic [31:0]     r_beat_cnt;
    logic [31:0]     r_index;
    logic [31:0]     r_length;
    logic [2:0]      r_size;

    logic [ID_W-1:0] w_winner;
    logic            w_found;
    logic [31:0]     w_sel_index;
    logic [31:0]     w_sel_length;
    logic [2:0]      w_sel_size;
    logic            w_accept;
    logic            w_ctrl_fire;
    logic            w_beat_fire;

    // Requester reached 'offset' positions after 'base' in round-robin order.
    function automatic logic [ID_W-1:0] f_rr_index(input logic [ID_W-1:0] base,
                                                   input int offset);
        int t;
        t = (int'(base) + offset) % NUM_REQ;
        return t[ID_W-1:0];
    endfunction

    // Search starts just after the last winner so every requester gets a turn.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!w_found && req_valid[f_rr_index(r_last_ptr, k)]) begin
                w_found  = 1'b1;
                w_winner = f_rr_index(r_last_ptr, k);
            end
        end
    end

    always_comb begin
        w_sel_index  = '0;
        w_sel_length = '0;
        w_sel_size   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_winner == ID_W'(i)) begin
                w_sel_index  = req_index[32*i +: 32];
                w_sel_length = req_length[32*i +: 32];
                w_sel_size   = req_size[3*i +: 3];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt         = r_state;
        req_ready           = '0;
        rd_valid            = '0;
        dma_read_chnl_ready = 1'b0;
        dma_read_ctrl_valid = 1'b0;
        busy                = 1'b0;
        w_accept            = 1'b0;
        w_ctrl_fire         = 1'b0;
        w_beat_fire         = 1'b0;
        case (r_state)
            S_IDLE: begin
                // Gate on rst so no grant is visible while reset is held.
                if (w_found && rst) begin
                    req_ready[w_winner] = 1'b1;
                    w_accept            = 1'b1;
                    if (w_sel_length != 32'd0) begin
                        w_state_nxt = S_CTRL;
                    end
                end
            end
            S_CTRL: begin
                busy                = 1'b1;
                dma_read_ctrl_valid = 1'b1;
                if (dma_read_ctrl_ready) begin
                    w_ctrl_fire = 1'b1;
                    w_state_nxt = S_STREAM;
                end
            end
            S_STREAM: begin
                busy                   = 1'b1;
                rd_valid[r_grant_id]   = dma_read_chnl_valid;
                dma_read_chnl_ready    = rd_ready[r_grant_id];
                w_beat_fire            = dma_read_chnl_valid && rd_ready[r_grant_id];
                if (w_beat_fire && (r_beat_cnt == r_length - 32'd1)) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_last_ptr <= ID_W'(NUM_REQ - 1);
            r_grant_id <= '0;
            r_beat_cnt <= '0;
            r_index    <= '0;
            r_length   <= '0;
            r_size     <= '0;
        end else begin
            // Zero-length requests are latched too; they simply never leave IDLE.
            if (w_accept) begin
                r_last_ptr <= w_winner;
                r_grant_id <= w_winner;
                r_index    <= w_sel_index;
                r_length   <= w_sel_length;
                r_size     <= w_sel_size;
            end
            if (w_ctrl_fire) begin
                r_beat_cnt <= '0;
            end else if (w_beat_fire) begin
                r_beat_cnt <= r_beat_cnt + 32'd1;
            end
        end
    end

    assign rd_data                   = dma_read_chnl_data;
    assign dma_read_ctrl_data_index  = r_index;
    assign dma_read_ctrl_data_length = r_length;
    assign dma_read_ctrl_data_size   = r_size;
    assign grant_id                  = r_grant_id;

endmodule
`default_nettype wire
